// File: rtl/draw_sprite_32x32.sv
// Overlays a 32x32 ROM sprite onto the pixel stream at a position latched on each
// vblank rising edge; timing and background are realigned to the 3-cycle ROM path.
module draw_sprite_32x32 #(
    parameter int          IMG_WIDTH       = 32,
    parameter int          IMG_HEIGHT      = 32,
    parameter bit          TRANSPARENT_EN  = 1'b1,
    parameter logic [11:0] TRANSPARENT_RGB = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] rgb_pixel,
    output logic [9:0]  pixel_addr,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [12:0] SPR_W = 13'(IMG_WIDTH);
    localparam logic [12:0] SPR_H = 13'(IMG_HEIGHT);

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_win;
    } pix_t;

    function automatic logic [11:0] compose(input logic in_win,
                                            input logic [11:0] bg,
                                            input logic [11:0] fg);
        if (!in_win || (TRANSPARENT_EN && fg == TRANSPARENT_RGB))
            return bg;
        return fg;
    endfunction

    logic        vblnk_prev;
    logic        armed;
    logic        lat_en;
    logic [11:0] x_lat;
    logic [11:0] y_lat;

    logic [12:0] h13, v13, x13, y13;
    logic [4:0]  col_p0, row_p0;
    pix_t        pix_p0, pix_p1, pix_p2;

    // armed keeps a vblank that is already high at reset release from latching
    assign lat_en = vblnk_in && !vblnk_prev && armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            armed      <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (!vblnk_in)
                armed <= 1'b1;
            if (lat_en) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // stage 0: window test and address, 13-bit so x_lat+32 cannot wrap
    always_comb begin
        h13    = {2'b00, hcount_in};
        v13    = {2'b00, vcount_in};
        x13    = {1'b0, x_lat};
        y13    = {1'b0, y_lat};
        col_p0 = hcount_in[4:0] - x_lat[4:0];
        row_p0 = vcount_in[4:0] - y_lat[4:0];

        pix_p0        = '0;
        pix_p0.hcount = hcount_in;
        pix_p0.hsync  = hsync_in;
        pix_p0.hblnk  = hblnk_in;
        pix_p0.vcount = vcount_in;
        pix_p0.vsync  = vsync_in;
        pix_p0.vblnk  = vblnk_in;
        pix_p0.rgb    = rgb_in;
        pix_p0.in_win = !hblnk_in && !vblnk_in &&
                        (h13 >= x13) && (h13 < x13 + SPR_W) &&
                        (v13 >= y13) && (v13 < y13 + SPR_H);
    end

    // stage 1: ROM address issued; stage 2: ROM data aligned with delayed stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            pix_p1     <= '0;
            pix_p2     <= '0;
        end else begin
            pixel_addr <= {row_p0, col_p0};
            pix_p1     <= pix_p0;
            pix_p2     <= pix_p1;
        end
    end

    // stage 3: composited output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= pix_p2.hcount;
            hsync_out  <= pix_p2.hsync;
            hblnk_out  <= pix_p2.hblnk;
            vcount_out <= pix_p2.vcount;
            vsync_out  <= pix_p2.vsync;
            vblnk_out  <= pix_p2.vblnk;
            rgb_out    <= compose(pix_p2.in_win, pix_p2.rgb, rgb_pixel);
        end
    end

endmodule

// File: tb/tb_draw_sprite_32x32.sv
// Scoreboard bench for draw_sprite_32x32: two instances (colour key on/off) share
// one stimulus stream; a spec-level model predicts every output cycle.
module tb_draw_sprite_32x32;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;

    logic [11:0] px1, px0;
    logic [9:0]  addr1, addr0;
    logic [10:0] hc1, vc1, hc0, vc0;
    logic        hs1, hb1, vs1, vb1, hs0, hb0, vs0, vb0;
    logic [11:0] ro1, ro0;

    draw_sprite_32x32 #(.TRANSPARENT_EN(1'b1), .TRANSPARENT_RGB(12'h000)) dut_key (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(px1),
        .pixel_addr(addr1),
        .hcount_out(hc1), .hsync_out(hs1), .hblnk_out(hb1),
        .vcount_out(vc1), .vsync_out(vs1), .vblnk_out(vb1),
        .rgb_out(ro1)
    );

    draw_sprite_32x32 #(.TRANSPARENT_EN(1'b0), .TRANSPARENT_RGB(12'h000)) dut_nokey (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(px0),
        .pixel_addr(addr0),
        .hcount_out(hc0), .hsync_out(hs0), .hblnk_out(hb0),
        .vcount_out(vc0), .vsync_out(vs0), .vblnk_out(vb0),
        .rgb_out(ro0)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [1024];
    always @(posedge clk) begin
        px1 <= rom[addr1];
        px0 <= rom[addr0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [10:0] hc, vc;
        logic        hs, hb, vs, vb;
        logic [11:0] r1, r0;
    } exp_t;
    typedef struct {
        int         due;
        logic [9:0] a;
    } aexp_t;

    exp_t  q[$];
    aexp_t aq[$];

    int n_cmp = 0;
    int n_err = 0;

    // model state: latched position and last vblank seen since reset (1 = none yet)
    int xm, ym, prev_vb;
    int cx, cy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rgb1"}, 32'(ro1), 0);
        chk({tag, "_rgb0"}, 32'(ro0), 0);
        chk({tag, "_hc"},   32'(hc1), 0);
        chk({tag, "_vc"},   32'(vc0), 0);
        chk({tag, "_flags"}, 32'({hs1, hb1, vs1, vb1, hs0, hb0, vs0, vb0}), 0);
        chk({tag, "_addr"}, 32'({addr1, addr0}), 0);
    endtask

    task automatic push_zero(input int due);
        exp_t e;
        e = '{due: due, hc: 0, vc: 0, hs: 0, hb: 0, vs: 0, vb: 0, r1: 0, r0: 0};
        q.push_back(e);
    endtask

    // apply one pixel now (sampled at the next edge) and predict its outputs
    task automatic put(input int h, input int v, input bit hb, input bit vb, input int rgb);
        exp_t  e;
        aexp_t ae;
        bit    win;
        int    a;
        logic [11:0] pix;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = (h % 7) == 3;
        vsync_in  = vb && (v % 3 == 1);
        rgb_in    = 12'(rgb);
        xpos      = 12'(cx);
        ypos      = 12'(cy);

        win = !hb && !vb && h >= xm && h < xm + 32 && v >= ym && v < ym + 32;
        e.due = cyc + 3;
        e.hc = hcount_in; e.vc = vcount_in;
        e.hs = hsync_in;  e.hb = hb; e.vs = vsync_in; e.vb = vb;
        e.r1 = rgb_in;    e.r0 = rgb_in;
        if (win) begin
            a   = (v - ym) * 32 + (h - xm);
            pix = rom[a];
            e.r0 = pix;
            e.r1 = (pix == 12'h000) ? rgb_in : pix;
            ae.due = cyc + 1;
            ae.a   = 10'(a);
            aq.push_back(ae);
        end
        q.push_back(e);

        if (vb && prev_vb == 0) begin
            xm = cx;
            ym = cy;
        end
        prev_vb = vb ? 1 : 0;
    endtask

    task automatic pix(input int h, input int v, input bit hb, input bit vb, input int rgb);
        @(posedge clk);
        #1;
        put(h, v, hb, vb, rgb);
    endtask

    task automatic vblank_pulse();
        pix(0, 600, 1, 0, 0);
        pix(0, 601, 1, 1, 0);
        pix(0, 602, 1, 1, 0);
        pix(0, 0, 1, 0, 0);
    endtask

    // assert rst between edges, check outputs cleared asynchronously, then release
    task automatic async_reset(input bit vb_at_release);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        q.delete();
        aq.delete();
        xm = 0; ym = 0; prev_vb = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b0;
        push_zero(cyc + 1);
        push_zero(cyc + 2);
        put(0, 0, 1, vb_at_release, 12'h123);
    endtask

    // monitor: compares every output cycle against queued predictions
    initial begin
        exp_t  e;
        aexp_t ae;
        forever begin
            @(negedge clk);
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                ae = aq.pop_front();
                chk("pixel_addr_key",   32'(addr1), 32'(ae.a));
                chk("pixel_addr_nokey", 32'(addr0), 32'(ae.a));
            end
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("rgb_out_key",   32'(ro1), 32'(e.r1));
                chk("rgb_out_nokey", 32'(ro0), 32'(e.r0));
                chk("hcount_out", 32'(hc1), 32'(e.hc));
                chk("vcount_out", 32'(vc0), 32'(e.vc));
                chk("sync_blank_key",   32'({hs1, hb1, vs1, vb1}), 32'({e.hs, e.hb, e.vs, e.vb}));
                chk("sync_blank_nokey", 32'({hs0, hb0, vs0, vb0}), 32'({e.hs, e.hb, e.vs, e.vb}));
            end
        end
    end

    initial begin
        int h, v, guard;
        for (int a = 0; a < 1024; a++) rom[a] = 12'($urandom_range(1, 4095));
        rom[5]   = 12'h000;
        rom[700] = 12'h000;

        rst = 1'b1;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
        vsync_in = 0; vblnk_in = 0; rgb_in = '0; xpos = '0; ypos = '0;
        xm = 0; ym = 0; prev_vb = 1;
        cx = 300; cy = 300;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");

        // release with vblank already high: must not latch 300/300
        rst = 1'b0;
        push_zero(cyc + 1);
        push_zero(cyc + 2);
        put(0, 0, 1, 1, 0);
        pix(0, 0, 1, 1, 0);
        pix(0, 0, 0, 0, 12'h0F0);
        pix(31, 31, 0, 0, 12'h0F0);
        pix(32, 0, 0, 0, 12'h0F0);

        // latch at 100/50, placement and alignment
        cx = 100; cy = 50;
        pix(100, 50, 0, 0, 12'h0F0);
        vblank_pulse();
        pix(100, 50, 0, 0, 12'h0F0);
        pix(131, 81, 0, 0, 12'h0F0);
        pix(132, 50, 0, 0, 12'h0F0);
        pix(99, 50, 0, 0, 12'h0F0);
        pix(105, 50, 0, 0, 12'hABC);
        pix(104, 52, 0, 0, 12'hABC);

        // new xpos mid-frame only takes effect after vblank
        cx = 200;
        pix(100, 51, 0, 0, 12'h0F0);
        pix(200, 51, 0, 0, 12'h0F0);
        vblank_pulse();
        pix(100, 51, 0, 0, 12'h0F0);
        pix(200, 51, 0, 0, 12'h0F0);
        pix(231, 51, 0, 0, 12'h0F0);

        // clipping at the right edge, no wrap onto the next line
        cx = 790; cy = 10;
        vblank_pulse();
        for (int i = 780; i < 800; i++) pix(i, 10, 0, 0, 12'h0F0);
        for (int i = 800; i < 806; i++) pix(i, 10, 1, 0, 12'h0F0);
        for (int i = 0; i < 26; i++)    pix(i, 11, 0, 0, 12'h0F0);

        cx = 4090; cy = 0;
        vblank_pulse();
        for (int i = 0; i < 40; i++) pix(i, i, 0, 0, 12'h333);
        pix(2047, 5, 0, 0, 12'h333);

        // horizontal blank inside the window passes the background
        cx = 100; cy = 50;
        vblank_pulse();
        for (int i = 95; i < 140; i++) pix(i, 60, (i >= 110 && i <= 120), 0, 12'h5A5);

        // async reset while inside the sprite, then latch stays 0
        for (int i = 100; i < 106; i++) pix(i, 55, 0, 0, 12'h0F0);
        async_reset(1'b0);
        cx = 500; cy = 500;
        for (int i = 0; i < 8; i++) pix(i, 3, 0, 0, 12'h777);
        pix(100, 55, 0, 0, 12'h777);
        vblank_pulse();
        pix(5, 3, 0, 0, 12'h777);
        pix(505, 503, 0, 0, 12'h777);

        // randomized frames around the latched sprite
        for (int f = 0; f < 15; f++) begin
            cx = $urandom_range(0, 2100);
            cy = $urandom_range(0, 2100);
            if ($urandom_range(0, 3) == 0) cx = $urandom_range(0, 4095);
            vblank_pulse();
            for (int i = 0; i < 200; i++) begin
                h = xm + $urandom_range(0, 45) - 6;
                v = ym + $urandom_range(0, 45) - 6;
                if (h < 0) h = 0;
                if (h > 2047) h = 2047;
                if (v < 0) v = 0;
                if (v > 2047) v = 2047;
                pix(h, v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
                    $urandom_range(0, 4095));
            end
        end

        for (int i = 0; i < 6; i++) pix(0, 0, 1, 0, 0);
        guard = 0;
        while ((q.size() > 0 || aq.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0 || aq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d outputs never observed, required 0", q.size() + aq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/draw_sprite_32x32.md
# draw_sprite_32x32

Reads a 32x32 sprite from the synchronous image ROM and overlays it onto the VGA pixel stream at a frame-latched (xpos, ypos). Sits in the video chain between the timing generator or background stage and the next draw stage. Drives the ROM address and consumes its 1-cycle-latency RGB output. Realigns all timing signals so the output stream stays coherent.

## Interface

Parameters:
- IMG_WIDTH, 32, sprite width in pixels; must equal 32 for the 10-bit address.
- IMG_HEIGHT, 32, sprite height in pixels; must equal 32.
- TRANSPARENT_EN, 1, when 1, ROM pixels equal to TRANSPARENT_RGB pass the background through.
- TRANSPARENT_RGB, 12'h000, colour-key value.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- vcount_in  in  11  vertical line counter.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  background pixel {r,g,b} 4 bits each.
- xpos  in  12  sprite left edge, unsigned.
- ypos  in  12  sprite top edge, unsigned.
- rgb_pixel  in  12  ROM data; valid 1 cycle after pixel_addr.
- pixel_addr  out  10  ROM address {row[4:0], col[4:0]}.
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  inputs delayed 3 cycles.
- rgb_out  out  12  composited pixel.

## Operation

- Position latch:
  - x_lat and y_lat (12 bit) load xpos and ypos on the cycle where vblnk_in=1 and the registered previous vblnk=0 (rising edge of vblank). They hold at all other times.
  - Reset value 0; the previous-vblnk register resets to 0.
  - A vblnk already high at reset release does not latch until the next rising edge.
- Window test, combinational on stage-0 inputs:
  - in_win = !hblnk_in && !vblnk_in && hcount_in ≥ x_lat && hcount_in < x_lat+32 && vcount_in ≥ y_lat && vcount_in < y_lat+32.
  - Comparisons use 13-bit unsigned arithmetic, so x_lat+32 never wraps. A sprite at x_lat ≥ 4064 is never visible.
  - Partial off-screen sprites clip naturally; no wrap to the opposite edge.
- Address:
  - pixel_addr ← {(vcount_in−y_lat)[4:0], (hcount_in−x_lat)[4:0]}, registered.
  - Outside the window it may take any value; the window flag gates its use.
- Pipeline:
  - Stage 1: register pixel_addr; delay timing, rgb_in and in_win by one.
  - Stage 2: ROM returns rgb_pixel; delay all signals again.
  - Stage 3: output register. rgb_out = rgb_in_d2 if !in_win_d2, or if TRANSPARENT_EN && rgb_pixel==TRANSPARENT_RGB; otherwise rgb_pixel.
- The latch update and the window test on the same cycle use the old latch value, so the new position takes effect on the next cycle. Vblank pixels are never in-window, so this is harmless.

## Timing

- Latency: every *_out and rgb_out corresponds to the inputs 3 clocks earlier. pixel_addr leads rgb_out by 2 clocks.
- Reset: all pipeline registers, all *_out, rgb_out, pixel_addr, x_lat and y_lat are 0 while rst=1. Assertion mid-frame clears them immediately, without waiting for a clock.
- After reset release, the first 3 output cycles carry zeros, then the stream resumes.
- No handshake; one pixel per clock, no stalls.

## Test plan

- Latch: xpos=100, ypos=50 applied mid-frame, then changed to 200 before vblank. Required: sprite is still drawn at the old position this frame; 200 takes effect only after the vblnk rising edge.
- Placement and alignment: x_lat=100, y_lat=50; ROM model holds rgb=addr-derived pattern, rgb_in=12'h0F0.
  - Input hcount=100, vcount=50 gives pixel_addr=0 and, 3 cycles later, rgb_out=ROM[0] with hcount_out=100.
  - hcount=131, vcount=81 gives addr 10'h3FF.
  - hcount=132 or 99 gives rgb_out=12'h0F0.
- Transparency: ROM[5]=12'h000, TRANSPARENT_EN=1, rgb_in=12'hABC. Required: rgb_out=12'hABC at that pixel; with TRANSPARENT_EN=0, rgb_out=12'h000.
- Clipping: x_lat=790 on an 800-wide line. Required: columns 0–9 are drawn at hcount 790–799, nothing is drawn at hcount 0–21 of the next line, and no wrap occurs. x_lat=4090 gives no sprite pixels.
- Blanking: a window overlapping hblnk=1 cycles gives rgb_out=rgb_in delayed there.
- Async reset: assert rst mid-sprite between clock edges. Required: all outputs are 0 before the next edge; after release, the latch holds 0 until the first vblank rising edge, and the first 3 output cycles are zero.
